// File: rtl/sdram_responder.sv
// Word-organized memory standing in for external SDRAM on the memory_control read/write interface.
// Define SDRAM_RESPONDER_STATS_EN to add saturating read/write/error completion counters.
module sdram_responder #(
  parameter int unsigned W      = 16,
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned DEPTH  = 8192,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SDRAM_RESPONDER_STATS_EN
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic [31:0]       err_count,
`endif
  input  logic              read,
  input  logic [ADDR_W-1:0] readaddress,
  output logic [W-1:0]      readdata,
  output logic              readdatavalid,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeaddress,
  input  logic [W-1:0]      writedata,
  output logic              writedone,
  output logic              waitrequest,
  output logic              addr_err
);

  localparam int unsigned Lw     = $clog2(W);
  localparam int unsigned IdxW   = ADDR_W - Lw;
  localparam int unsigned MemAw  = $clog2(DEPTH);
  localparam int unsigned MaxLat = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  localparam logic [IdxW:0]   DepthL = (IdxW + 1)'(DEPTH);
  localparam logic [CntW-1:0] RdCnt  = CntW'(RD_LAT - 1);
  localparam logic [CntW-1:0] WrCnt  = CntW'(WR_LAT - 1);

  typedef enum logic [1:0] {StIdle, StRdWait, StWrWait} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [MemAw-1:0]  idx_q, idx_d;
  logic              err_q, err_d;
  logic [W-1:0]      readdata_q, readdata_d;
  logic              rdv_q, rdv_d;
  logic              wd_q, wd_d;
  logic              wait_q, wait_d;
  logic              aerr_q, aerr_d;
  logic              mem_we;

  logic [W-1:0]      mem_q [DEPTH];

  // Read has priority, so the decoded address follows the read port whenever read is high.
  logic [ADDR_W-1:0] req_addr;
  logic [IdxW-1:0]   req_idx;
  logic              req_err;

  assign req_addr = read ? readaddress : writeaddress;
  assign req_idx  = req_addr[ADDR_W-1:Lw];
  assign req_err  = (req_addr[Lw-1:0] != '0) || ({1'b0, req_idx} >= DepthL);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    err_d      = err_q;
    readdata_d = readdata_q;
    rdv_d      = 1'b0;
    wd_d       = 1'b0;
    aerr_d     = 1'b0;
    wait_d     = wait_q;
    mem_we     = 1'b0;
    case (state_q)
      StIdle: begin
        if (read) begin
          idx_d   = req_idx[MemAw-1:0];
          err_d   = req_err;
          cnt_d   = RdCnt;
          wait_d  = 1'b1;
          state_d = StRdWait;
        end else if (write) begin
          idx_d   = req_idx[MemAw-1:0];
          err_d   = req_err;
          mem_we  = !req_err;
          cnt_d   = WrCnt;
          wait_d  = 1'b1;
          state_d = StWrWait;
        end
      end
      StRdWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          readdata_d = err_q ? '0 : mem_q[idx_q];
          rdv_d      = 1'b1;
          aerr_d     = err_q;
          wait_d     = 1'b0;
          state_d    = StIdle;
        end
      end
      StWrWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          wd_d    = 1'b1;
          aerr_d  = err_q;
          wait_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      readdata_q <= '0;
      rdv_q      <= 1'b0;
      wd_q       <= 1'b0;
      wait_q     <= 1'b0;
      aerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      readdata_q <= readdata_d;
      rdv_q      <= rdv_d;
      wd_q       <= wd_d;
      wait_q     <= wait_d;
      aerr_q     <= aerr_d;
    end
  end

  // Storage is deliberately not reset; a write committed before reset survives it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[req_idx[MemAw-1:0]] <= writedata;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rdv_q;
  assign writedone     = wd_q;
  assign waitrequest   = wait_q;
  assign addr_err      = aerr_q;

`ifdef SDRAM_RESPONDER_STATS_EN
  logic [31:0] rd_count_q, wr_count_q, err_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      if (rdv_d && (rd_count_q != '1)) rd_count_q <= rd_count_q + 32'd1;
      if (wd_d && (wr_count_q != '1)) wr_count_q <= wr_count_q + 32'd1;
      if (aerr_d && (err_count_q != '1)) err_count_q <= err_count_q + 32'd1;
    end
  end

  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// Scoreboard bench for sdram_responder: stimulus pushes expected completions, a monitor pops them.
module tb_sdram_responder;

  localparam int unsigned W      = 16;
  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DEPTH  = 8192;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned WR_LAT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              read = 1'b0;
  logic [ADDR_W-1:0] readaddress = '0;
  logic [W-1:0]      readdata;
  logic              readdatavalid;
  logic              write = 1'b0;
  logic [ADDR_W-1:0] writeaddress = '0;
  logic [W-1:0]      writedata = '0;
  logic              writedone;
  logic              waitrequest;
  logic              addr_err;
`ifdef SDRAM_RESPONDER_STATS_EN
  logic [31:0]       rd_count, wr_count, err_count;
`endif

  sdram_responder #(
    .W(W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef SDRAM_RESPONDER_STATS_EN
    .rd_count(rd_count),
    .wr_count(wr_count),
    .err_count(err_count),
`endif
    .read(read),
    .readaddress(readaddress),
    .readdata(readdata),
    .readdatavalid(readdatavalid),
    .write(write),
    .writeaddress(writeaddress),
    .writedata(writedata),
    .writedone(writedone),
    .waitrequest(waitrequest),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_rd;
    logic [15:0] data;
    bit          err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int n_rd = 0, n_wr = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (readdatavalid || writedone) begin
        if (sb.size() == 0) begin
          chk("spurious_pulse", {30'd0, readdatavalid, writedone}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pulse_kind", {30'd0, readdatavalid, writedone}, e.is_rd ? 32'd2 : 32'd1);
          chk("latency", cyc, e.due);
          if (e.is_rd) chk("readdata", {16'd0, readdata}, {16'd0, e.data});
          chk("addr_err", {31'd0, addr_err}, {31'd0, e.err});
        end
      end else if (addr_err) begin
        chk("stray_addr_err", {31'd0, addr_err}, 32'd0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((waitrequest || sb.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (waitrequest || sb.size() != 0) begin
      chk("idle_timeout_pending", sb.size(), 32'd0);
      chk("idle_timeout_wait", {31'd0, waitrequest}, 32'd0);
      sb.delete();
    end
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [15:0] d, input bit e);
    exp_t x;
    wait_idle();
    readaddress = a;
    read = 1'b1;
    @(posedge clk);
    #1;
    read = 1'b0;
    x.is_rd = 1'b1; x.data = d; x.err = e; x.due = cyc + RD_LAT;
    sb.push_back(x);
    n_rd++;
    if (e) n_err++;
    chk("rd_waitreq", {31'd0, waitrequest}, 32'd1);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [15:0] d, input bit e);
    exp_t x;
    wait_idle();
    writeaddress = a;
    writedata = d;
    write = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
    x.is_rd = 1'b0; x.data = 16'h0; x.err = e; x.due = cyc + WR_LAT;
    sb.push_back(x);
    n_wr++;
    if (e) n_err++;
    chk("wr_waitreq", {31'd0, waitrequest}, 32'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_readdata"}, {16'd0, readdata}, 32'd0);
    chk({tag, "_readdatavalid"}, {31'd0, readdatavalid}, 32'd0);
    chk({tag, "_writedone"}, {31'd0, writedone}, 32'd0);
    chk({tag, "_waitrequest"}, {31'd0, waitrequest}, 32'd0);
    chk({tag, "_addr_err"}, {31'd0, addr_err}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Write then read, with waitrequest held for the full write latency.
    do_write(25'd32, 16'h1234, 1'b0);
    for (int k = 0; k < WR_LAT - 1; k++) begin
      @(posedge clk);
      #1;
      chk("wr_busy", {31'd0, waitrequest}, 32'd1);
    end
    do_read(25'd32, 16'h1234, 1'b0);

    // Misaligned read returns zero and leaves memory untouched.
    do_read(25'd33, 16'h0000, 1'b1);
    do_read(25'd32, 16'h1234, 1'b0);

    // Out-of-range write is dropped.
    do_write(25'd0, 16'h0A0A, 1'b0);
    do_write(25'(16 * DEPTH), 16'hFFFF, 1'b1);
    do_read(25'd0, 16'h0A0A, 1'b0);

    // Simultaneous read and write: read wins, write is discarded.
    do_write(25'd16, 16'h5555, 1'b0);
    wait_idle();
    begin
      exp_t x;
      readaddress = 25'd0;
      writeaddress = 25'd16;
      writedata = 16'h9999;
      read = 1'b1;
      write = 1'b1;
      @(posedge clk);
      #1;
      read = 1'b0;
      write = 1'b0;
      x.is_rd = 1'b1; x.data = 16'h0A0A; x.err = 1'b0; x.due = cyc + RD_LAT;
      sb.push_back(x);
      n_rd++;
      readaddress = 25'd32;
      writeaddress = 25'd48;
      @(posedge clk);
      #1;
      write = 1'b1;
      writeaddress = 25'd16;
      writedata = 16'h7777;
      #4;
      write = 1'b0;
    end
    do_read(25'd16, 16'h5555, 1'b0);

    // Reset three cycles into a write: no completion, but the data is committed.
    do_write(25'd48, 16'hBEEF, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    n_rd = 0;
    n_wr = 0;
    n_err = 0;
    #1;
    chk_outputs_zero("midop_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    do_read(25'd48, 16'hBEEF, 1'b0);

    // Back-to-back reads at minimum spacing with read held high throughout.
    for (int i = 0; i < 10; i++) begin
      do_write(25'(16 * (200 + i)), 16'(16'h1000 + 16'h0111 * i), 1'b0);
    end
    wait_idle();
    read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_t x;
      readaddress = 25'(16 * (200 + i));
      @(posedge clk);
      #1;
      x.is_rd = 1'b1; x.data = 16'(16'h1000 + 16'h0111 * i); x.err = 1'b0;
      x.due = cyc + RD_LAT;
      sb.push_back(x);
      n_rd++;
      readaddress = 25'd33;
      repeat (2) begin
        @(posedge clk);
        #1;
      end
    end
    read = 1'b0;
    wait_idle();

`ifdef SDRAM_RESPONDER_STATS_EN
    chk("rd_count", rd_count, n_rd);
    chk("wr_count", wr_count, n_wr);
    chk("err_count", err_count, n_err);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("final_pending", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
